// File: rtl/fir_pkg.sv
// Shared constants, types and helpers for the time-multiplexed FIR sequencer
// and the parallel low-pass filter it replaces.
package fir_pkg;

    localparam int N_SAMPLES = 256;
    localparam int TAPS      = 50;
    localparam int FRAC_BITS = 14;
    localparam int ACC_W     = 32;
    localparam int ADDR_W    = $clog2(N_SAMPLES);
    localparam int CIDX_W    = $clog2(TAPS);

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE
    } state_t;

    // Saturate a shifted accumulator into the unsigned 8-bit output range.
    function automatic logic [7:0] clamp_u8(input acc_t value);
        if (value < acc_t'(0))
            return 8'd0;
        else if (value > acc_t'(255))
            return 8'hFF;
        else
            return value[7:0];
    endfunction

endpackage

// File: rtl/fir_frame_sequencer_if.sv
// Frame handshake plus sample, coefficient and output memory ports of the
// FIR sequencer, seen from the sequencer (master) and its environment (slave).
interface fir_frame_sequencer_if;
    import fir_pkg::*;

    logic                     start_flg;
    logic                     busy;
    logic                     rdy_flg;
    logic [ADDR_W-1:0]        smp_addr;
    logic [7:0]               smp_data;
    logic [CIDX_W-1:0]        coef_idx;
    logic signed [15:0]       coef_data;
    logic                     out_we;
    logic [ADDR_W-1:0]        out_addr;
    logic [7:0]               out_data;

    modport master (
        input  start_flg,
        input  smp_data,
        input  coef_data,
        output busy,
        output rdy_flg,
        output smp_addr,
        output coef_idx,
        output out_we,
        output out_addr,
        output out_data
    );

    modport slave (
        output start_flg,
        output smp_data,
        output coef_data,
        input  busy,
        input  rdy_flg,
        input  smp_addr,
        input  coef_idx,
        input  out_we,
        input  out_addr,
        input  out_data
    );

endinterface

// File: rtl/fir_mac_unit.sv
// Multiply-accumulate datapath: Q2.14 accumulate of unsigned samples times
// signed coefficients, with arithmetic shift and clamp to an 8-bit result.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               clr,
    input  logic [7:0]         smp,
    input  logic signed [15:0] coef,
    output logic [7:0]         result
);

    acc_t acc;
    acc_t product;
    acc_t acc_sum;

    // result reflects the accumulator including this cycle's product, so the
    // sequencer can register it on the same edge the final tap lands.
    always_comb begin
        product = acc_t'($signed({1'b0, smp})) * acc_t'(coef);
        acc_sum = valid ? acc + product : acc;
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else
            acc <= acc_sum;
    end

    assign result = clamp_u8(acc_sum >>> FRAC_BITS);

endmodule

// File: rtl/fir_frame_sequencer.sv
// Walks samples and taps of a 256-sample frame through one shared MAC,
// writing one clamped result per sample and owning the start/ready handshake.
module fir_frame_sequencer
    import fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fir_frame_sequencer_if.master bus
);

    state_t              state;
    logic [ADDR_W-1:0]   i;
    logic [ADDR_W-1:0]   smp_addr_q;
    logic [CIDX_W-1:0]   coef_idx_q;
    logic                tap_vld;
    logic                busy_q;
    logic                rdy_q;
    logic                out_we_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [7:0]          out_data_q;
    logic [7:0]          mac_result;
    logic                last_tap;

    // coef_idx_q doubles as the tap counter j; smp_addr_q tracks i-j alongside it.
    assign last_tap = (coef_idx_q == CIDX_W'(TAPS - 1)) ||
                      (ADDR_W'(coef_idx_q) == i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            i          <= '0;
            smp_addr_q <= '0;
            coef_idx_q <= '0;
            tap_vld    <= 1'b0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            tap_vld <= (state == ISSUE);
            case (state)
                IDLE: begin
                    if (bus.start_flg) begin
                        state      <= ISSUE;
                        rdy_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        i          <= '0;
                        smp_addr_q <= '0;
                        coef_idx_q <= '0;
                    end
                end
                ISSUE: begin
                    if (last_tap) begin
                        state      <= DRAIN;
                        smp_addr_q <= '0;
                        coef_idx_q <= '0;
                    end else begin
                        smp_addr_q <= smp_addr_q - ADDR_W'(1);
                        coef_idx_q <= coef_idx_q + CIDX_W'(1);
                    end
                end
                DRAIN: begin
                    state      <= WRITE;
                    out_we_q   <= 1'b1;
                    out_addr_q <= i;
                    out_data_q <= mac_result;
                end
                WRITE: begin
                    out_we_q <= 1'b0;
                    if (i == ADDR_W'(N_SAMPLES - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        rdy_q  <= 1'b1;
                    end else begin
                        state      <= ISSUE;
                        i          <= i + ADDR_W'(1);
                        smp_addr_q <= i + ADDR_W'(1);
                        coef_idx_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fir_mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .valid  (tap_vld),
        .clr    (state == WRITE),
        .smp    (bus.smp_data),
        .coef   (bus.coef_data),
        .result (mac_result)
    );

    assign bus.busy     = busy_q;
    assign bus.rdy_flg  = rdy_q;
    assign bus.smp_addr = smp_addr_q;
    assign bus.coef_idx = coef_idx_q;
    assign bus.out_we   = out_we_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_data = out_data_q;

endmodule

// File: doc/fir_frame_sequencer.md
Name: fir_frame_sequencer

Overview:
Time-multiplexes one multiply-accumulate datapath across a 256-sample frame. It is a sequential replacement for the fully parallel low-pass FIR.
- Walks sample index i and tap index j, addressing external sample memory and coefficient memory.
- Accumulates in Q2.14, then shifts, clamps and writes one 8-bit unsigned result per sample to output memory.
- Owns the start_flg/rdy_flg frame handshake toward the system controller.

Parameters:
N_SAMPLES, 256, samples per frame
TAPS, 50, filter length
FRAC_BITS, 14, coefficient fractional bits (Q2.14)
ACC_W, 32, signed accumulator width
ADDR_W, 8, $clog2(N_SAMPLES)
CIDX_W, 6, $clog2(TAPS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start_flg  in  1  frame start request; sampled only in IDLE
busy  out  1  high while a frame is in progress
rdy_flg  out  1  frame complete; sticky
smp_addr  out  ADDR_W  sample memory read address; read data returns next cycle
smp_data  in  8  unsigned sample read data
coef_idx  out  CIDX_W  coefficient memory index; read data returns next cycle
coef_data  in  16  signed Q2.14 coefficient
out_we  out  1  output memory write strobe, one cycle per sample
out_addr  out  ADDR_W  output write address, equal to i
out_data  out  8  clamped result

Behaviour:
- Reset: synchronous, active-high.
  - While rst is high, the FSM goes to IDLE on the next edge.
  - busy, rdy_flg, out_we, smp_addr, coef_idx, out_addr, out_data and acc all become 0.
  - Reset mid-frame aborts the frame: no out_we after the reset edge and no partial rdy_flg.
- FSM states: IDLE, ISSUE, DRAIN, WRITE.
  - IDLE with start_flg=1: rdy_flg cleared, busy set, i=0, j=0, go to ISSUE.
  - start_flg in any other state is ignored; it is not queued.
  - ISSUE: drive smp_addr=i-j and coef_idx=j, one tap per cycle.
    - The last tap is j=min(i,TAPS-1); taps with i-j<0 are never issued.
    - After the last tap, go to DRAIN.
  - DRAIN: one cycle in which the final product is accumulated; then go to WRITE.
  - WRITE: out_we=1 for exactly this cycle, with out_addr=i and out_data=clamp(acc>>>FRAC_BITS). acc is cleared.
    - If i==N_SAMPLES-1: go to IDLE, busy<=0, rdy_flg<=1.
    - Otherwise: i<=i+1, j<=0, go to ISSUE.
- Pipeline: a tap-valid flag is delayed one cycle, matching memory read latency. In any cycle where the delayed valid is set, acc<=acc+product.
- Arithmetic:
  - product = signed 9-bit {1'b0,smp_data} × signed 16-bit coef_data, giving a 25-bit signed value sign-extended to ACC_W.
  - The shift is arithmetic.
  - Clamp: result <0 → 0; result >255 → 255; otherwise the low 8 bits.
  - No accumulator saturation. The ACC_W default covers TAPS·255·32767.
- Timing per sample: min(i+1,TAPS)+2 cycles.
  - Defaults: 11575 ISSUE + 256 DRAIN + 256 WRITE = 12087 cycles.
  - rdy_flg is high after the 12087th rising edge following the edge that accepted start.
- Outside ISSUE, smp_addr and coef_idx are 0. out_data holds its last value when out_we=0.
- rdy_flg stays high until the next accepted start_flg or reset. It falls on the accepting edge.
- A frame with all start conditions met on the cycle after WRITE of sample 255 is legal. The IDLE dwell is at least one cycle.

Decomposition:
- Package fir_pkg holds:
  - N_SAMPLES, TAPS and FRAC_BITS constants;
  - the state enum (IDLE, ISSUE, DRAIN, WRITE);
  - the ACC_W typedef for the accumulator;
  - the clamp_u8 function, shared with the existing parallel filter.
- Sub-module fir_mac_unit holds the product, accumulate, clear and shift/clamp logic. Its inputs are valid, clr, smp and coef; its output is the 8-bit result.
- The FSM, counters and handshake stay in fir_frame_sequencer.

Test Plan:
1. Impulse: smp[0]=255, all other samples 0, lowpass coefficients (c0=40 … c24=642, symmetric) → out[0]=0, out[24]=9 ((255·642)>>14), out[k]=(255·c[k])>>14 for k<50, out[k]=0 for k≥50.
2. DC: all samples 255, same coefficients (sum 16382) → out[49..255]=254, out[0]=0, out monotonic non-decreasing over 0..49.
3. Clamp: coef[0]=32767, other coefficients 0, samples 255 → all out=255; coef[0]=-16384, samples 100 → all out=0.
4. Timing: single start pulse → exactly 256 out_we pulses with out_addr 0..255 ascending; rdy_flg rises after 12087 edges; busy high for the whole frame; rdy_flg stays high for 1000 idle cycles.
5. Handshake: start_flg held high during the frame → no restart and still exactly 256 writes; a new start after rdy_flg → rdy_flg drops on the accepting edge and a second identical frame runs.
6. Reset at cycle 500 of a frame → next cycle busy=0, rdy_flg=0, out_we=0, no further writes; a fresh start then completes with outputs identical to the golden model.
